// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: locks onto an hsync/vsync/video stream, recovers the pixel
// position and flags line, sync-width, frame and video-window violations.
module vga_timing_monitor #(
   parameter int unsigned hDisp  = 640,
   parameter int unsigned hFp    = 16,
   parameter int unsigned hPulse = 96,
   parameter int unsigned hBp    = 48,
   parameter int unsigned vDisp  = 480,
   parameter int unsigned vFp    = 10,
   parameter int unsigned vPulse = 2,
   parameter int unsigned vBp    = 33,
   parameter int unsigned CW     = 10
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_hsync,
   input  logic          i_vsync,
   input  logic          i_video,
   input  logic          i_clr_err,
   output logic [CW-1:0] o_x_counter,
   output logic [CW-1:0] o_y_counter,
   output logic          o_locked,
   output logic          o_frame_start,
   output logic [3:0]    o_err
);

   localparam int unsigned hTOT = hDisp + hFp + hPulse + hBp;
   localparam int unsigned vTOT = vDisp + vFp + vPulse + vBp;
   localparam int unsigned hSS  = hDisp + hFp;
   localparam int unsigned hSE  = hSS + hPulse;
   localparam int unsigned vSS  = vDisp + vFp;
   localparam int unsigned vSE  = vSS + vPulse;

   typedef enum logic [1:0] {IDLE, MEAS, WAIT_V, LOCKED} state_t;

   state_t        state;
   logic          s_hsync, s_vsync, s_video;
   logic          d_hsync, d_vsync;
   logic [CW-1:0] x, y, cnt;
   logic [CW-1:0] x_inc, y_inc;
   logic          x_wrap;
   logic          h_fall, h_rise, v_fall, v_rise;
   logic          h_bad, vf_bad;
   logic          vid_exp;
   logic [3:0]    err_set;

   // Edge detection on the sampled/delayed sync pair
   assign h_fall = ~s_hsync &  d_hsync;
   assign h_rise =  s_hsync & ~d_hsync;
   assign v_fall = ~s_vsync &  d_vsync;
   assign v_rise =  s_vsync & ~d_vsync;

   // Free-running position advance for the next sample
   assign x_wrap = (x == CW'(hTOT - 1));
   assign x_inc  = x_wrap ? '0 : x + CW'(1);
   assign y_inc  = x_wrap ? ((y == CW'(vTOT - 1)) ? '0 : y + CW'(1)) : y;

   // Violations of the current sample against the recovered position, only while locked
   always_comb begin
      err_set = '0;
      h_bad   = 1'b0;
      vf_bad  = 1'b0;
      vid_exp = (x < CW'(hDisp)) && (y < CW'(vDisp));
      if (state == LOCKED) begin
         h_bad      = h_fall && (x != CW'(hSS));
         vf_bad     = v_fall && ((x != '0) || (y != CW'(vSS)));
         err_set[0] = h_bad;
         err_set[1] = h_rise && (x != CW'(hSE));
         err_set[2] = vf_bad || (v_rise && ((x != '0) || (y != CW'(vSE))));
         err_set[3] = (s_video != vid_exp);
      end
   end

   // Input pipeline, lock FSM, position tracking and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s_hsync       <= 1'b1;
         s_vsync       <= 1'b1;
         s_video       <= 1'b1;
         d_hsync       <= 1'b1;
         d_vsync       <= 1'b1;
         state         <= IDLE;
         x             <= '0;
         y             <= '0;
         cnt           <= '0;
         o_x_counter   <= '0;
         o_y_counter   <= '0;
         o_locked      <= 1'b0;
         o_frame_start <= 1'b0;
         o_err         <= '0;
      end else begin
         s_hsync <= i_hsync;
         s_vsync <= i_vsync;
         s_video <= i_video;
         d_hsync <= s_hsync;
         d_vsync <= s_vsync;
         x       <= x_inc;
         y       <= y_inc;
         cnt     <= (cnt == '1) ? cnt : cnt + CW'(1);

         // A fall marks the current sample as column hSS, so the next one is hSS+1
         case (state)
            IDLE: begin
               if (h_fall) begin
                  x     <= CW'(hSS + 1);
                  cnt   <= CW'(1);
                  state <= MEAS;
               end
            end
            MEAS: begin
               if (h_fall) begin
                  x   <= CW'(hSS + 1);
                  cnt <= CW'(1);
                  if (cnt == CW'(hTOT))
                     state <= WAIT_V;
               end
            end
            WAIT_V: begin
               if (h_fall && (x != CW'(hSS))) begin
                  state <= IDLE;
               end else if (v_fall) begin
                  if (x == '0) begin
                     y     <= CW'(vSS);
                     state <= LOCKED;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            LOCKED: begin
               if (h_bad || vf_bad)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         o_locked      <= (state == LOCKED);
         o_x_counter   <= (state == LOCKED) ? x : '0;
         o_y_counter   <= (state == LOCKED) ? y : '0;
         o_frame_start <= (state == LOCKED) && (x == '0) && (y == '0);
         o_err         <= (i_clr_err ? 4'b0000 : o_err) | err_set;
      end
   end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 32x20 timing format.
module tb_vga_timing_monitor;

   localparam int HDISP = 16, HFP = 4, HPULSE = 6, HBP = 6;
   localparam int VDISP = 12, VFP = 2, VPULSE = 2, VBP = 4;
   localparam int HTOT  = HDISP + HFP + HPULSE + HBP;
   localparam int VTOT  = VDISP + VFP + VPULSE + VBP;
   localparam int HSS   = HDISP + HFP;
   localparam int HSE   = HSS + HPULSE;
   localparam int VSS   = VDISP + VFP;
   localparam int VSE   = VSS + VPULSE;
   localparam int FRAME = HTOT * VTOT;
   localparam int CW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          hsync, vsync, video, clr_err;
   logic [CW-1:0] x_counter, y_counter;
   logic          locked, frame_start;
   logic [3:0]    err;

   int checks   = 0;
   int failures = 0;

   // stream generator state: next position to drive plus fault knobs
   int hx = 0, vy = 0;
   int px_d1_x = -1, px_d1_y = -1, px_d2_x = -1, px_d2_y = -1;
   bit short_en = 0;  int short_row = 0;
   bit late_v   = 0;
   bit stuck_h  = 0;
   bit vg_en    = 0;  int vg_x = 0, vg_y = 0;
   bit hold_en  = 0;  int hold_x = 0, hold_y = 0;

   vga_timing_monitor #(
      .hDisp(HDISP), .hFp(HFP), .hPulse(HPULSE), .hBp(HBP),
      .vDisp(VDISP), .vFp(VFP), .vPulse(VPULSE), .vBp(VBP), .CW(CW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync), .i_video(video),
      .i_clr_err(clr_err), .o_x_counter(x_counter), .o_y_counter(y_counter),
      .o_locked(locked), .o_frame_start(frame_start), .o_err(err)
   );

   always #5 clk = ~clk;

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // drive one pixel of the stream, wait one clock, advance the generator
   task automatic clock_px();
      int hse_eff;
      hse_eff = (short_en && vy == short_row) ? HSE - 1 : HSE;
      hsync = stuck_h ? 1'b1 : !(hx >= HSS && hx < hse_eff);
      vsync = late_v ? !(vy >= VSS + 1 && vy < VSE) : !(vy >= VSS && vy < VSE);
      video = (hx < HDISP && vy < VDISP);
      if (vg_en && hx == vg_x && vy == vg_y) video = 1'b0;
      @(posedge clk);
      #1;
      px_d2_x = px_d1_x; px_d2_y = px_d1_y;
      px_d1_x = hx;      px_d1_y = vy;
      if (hold_en && hx == hold_x && vy == hold_y) begin
         hold_en = 0;
      end else if (hx == HTOT - 1) begin
         hx = 0;
         vy = (vy == VTOT - 1) ? 0 : vy + 1;
      end else begin
         hx = hx + 1;
      end
   endtask

   task automatic run_to(input int tx, input int ty);
      for (int i = 0; i < 2 * FRAME + HTOT && !(hx == tx && vy == ty); i++) clock_px();
   endtask

   task automatic wait_lock(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (locked === 1'b1) break;
         clock_px();
      end
      ok = (locked === 1'b1);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      clock_px();
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_err = 1'b0; hsync = 1'b1; vsync = 1'b1; video = 1'b0;
      #1;
      checks++;
      if ({locked, frame_start, err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags: locked=%b fs=%b err=%b, required 0/0/0000", locked, frame_start, err);
      end
      clock_px(); clock_px();
      checks++;
      if (x_counter !== '0 || y_counter !== '0) begin
         failures++;
         $display("FAIL reset_pos: x=%0d y=%0d, required 0 0", x_counter, y_counter);
      end
      rst = 1'b0;
      clock_px();
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_unlocked: locked=%b, required 0", locked);
      end
   endtask

   task automatic test_lock();
      bit ok;
      int bad_err = 0, bad_pos = 0, fs = 0;
      wait_lock(2 * FRAME, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL lock_time: locked=%b, required 1 within %0d cycles", locked, 2 * FRAME);
      end
      for (int i = 0; i < 3 * FRAME; i++) begin
         clock_px();
         if (err !== 4'b0000) bad_err++;
         if (locked !== 1'b1) bad_pos++;
         else if (x_counter !== CW'(px_d2_x) || y_counter !== CW'(px_d2_y)) bad_pos++;
         if (frame_start === 1'b1) begin
            fs++;
            if (px_d2_x != 0 || px_d2_y != 0) bad_pos++;
         end
      end
      checks++;
      if (bad_err !== 0) begin
         failures++;
         $display("FAIL lock_no_err: %0d cycles with err!=0, required 0", bad_err);
      end
      checks++;
      if (bad_pos !== 0) begin
         failures++;
         $display("FAIL lock_track: %0d position mismatches, required 0", bad_pos);
      end
      checks++;
      if (fs !== 3) begin
         failures++;
         $display("FAIL lock_frame_start: %0d pulses in 3 frames, required 3", fs);
      end
   endtask

   task automatic test_video();
      pulse_clr();
      vg_x = 10; vg_y = 10; vg_en = 1;
      run_to(13, 10);
      vg_en = 0;
      checks++;
      if (err !== 4'b1000) begin
         failures++;
         $display("FAIL video_err: err=%b, required 1000", err);
      end
      pulse_clr();
      checks++;
      if (err !== 4'b0000) begin
         failures++;
         $display("FAIL video_clear: err=%b, required 0000", err);
      end
      run_to(10, 10);
      vg_en = 1;
      clock_px();
      vg_en = 0;
      pulse_clr();
      clock_px();
      checks++;
      if (err !== 4'b1000 || locked !== 1'b1) begin
         failures++;
         $display("FAIL video_set_wins: err=%b locked=%b, required 1000/1", err, locked);
      end
   endtask

   task automatic test_hsync_short();
      pulse_clr();
      run_to(0, 5);
      short_row = 5; short_en = 1;
      run_to(HSE + 2, 5);
      short_en = 0;
      checks++;
      if (err !== 4'b0010) begin
         failures++;
         $display("FAIL hsync_width_err: err=%b, required 0010", err);
      end
      run_to(0, 7);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL hsync_width_lock: locked=%b, required 1", locked);
      end
   endtask

   task automatic test_line_stretch();
      bit ok;
      pulse_clr();
      run_to(0, 3);
      hold_x = HDISP + 2; hold_y = 3; hold_en = 1;
      run_to(HSS + 4, 3);
      checks++;
      if (err !== 4'b0001) begin
         failures++;
         $display("FAIL stretch_err: err=%b, required 0001", err);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL stretch_unlock: locked=%b, required 0", locked);
      end
      wait_lock(2 * FRAME, ok);
      checks++;
      if (ok !== 1'b1 || err !== 4'b0001) begin
         failures++;
         $display("FAIL stretch_relock: locked=%b err=%b, required 1/0001", locked, err);
      end
   endtask

   task automatic test_vsync_late();
      pulse_clr();
      run_to(0, VSS - 1);
      late_v = 1;
      run_to(3, VSS + 1);
      checks++;
      if (err !== 4'b0100) begin
         failures++;
         $display("FAIL vsync_late_err: err=%b, required 0100", err);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL vsync_late_unlock: locked=%b, required 0", locked);
      end
      run_to(0, 0);
      late_v = 0;
   endtask

   task automatic test_hsync_stuck();
      bit ok;
      int bad = 0;
      rst = 1'b1; stuck_h = 1;
      clock_px();
      rst = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         clock_px();
         if (locked !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0 || err !== 4'b0000) begin
         failures++;
         $display("FAIL stuck_idle: %0d locked cycles err=%b, required 0/0000", bad, err);
      end
      stuck_h = 0;
      wait_lock(2 * FRAME, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL stuck_recover: locked=%b, required 1", locked);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      run_to(20, 8);
      checks++;
      if (locked !== 1'b1 || x_counter !== CW'(18) || y_counter !== CW'(8)) begin
         failures++;
         $display("FAIL pre_reset_pos: locked=%b x=%0d y=%0d, required 1 18 8", locked, x_counter, y_counter);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({locked, frame_start, err, x_counter, y_counter} !== '0) begin
         failures++;
         $display("FAIL async_reset: locked=%b fs=%b err=%b x=%0d y=%0d, required all 0",
                  locked, frame_start, err, x_counter, y_counter);
      end
      clock_px(); clock_px();
      rst = 1'b0;
      wait_lock(2 * FRAME, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL reset_relock: locked=%b, required 1", locked);
      end
      clock_px(); clock_px();
      checks++;
      if (err !== 4'b0000 || x_counter !== CW'(px_d2_x) || y_counter !== CW'(px_d2_y)) begin
         failures++;
         $display("FAIL reset_relock_pos: err=%b x=%0d y=%0d, required 0000 %0d %0d",
                  err, x_counter, y_counter, px_d2_x, px_d2_y);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_video();
      test_hsync_short();
      test_line_stretch();
      test_vsync_late();
      test_hsync_stuck();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
